mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mdu_step.sv | 33 +++
 rtl/mdu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: multiply/divide opcodes, MDU FSM states and latched operation flags.
package mips_pkg;

    localparam int unsigned MDU_OP_W    = 2;
    localparam int unsigned MDU_STATE_W = 2;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [MDU_STATE_W-1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    // Per-operation flags captured at start and consumed in FIX.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
        logic div0;
    } mdu_flags_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on {acc_hi, acc_lo}.
module mdu_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] nxt_hi_c,
    output logic [XLEN-1:0] nxt_lo_c
);

    logic [XLEN:0] addend;
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        addend  = acc_lo[0] ? {1'b0, opnd} : '0;
        sum     = {1'b0, acc_hi} + addend;
        shifted = {acc_hi, acc_lo[XLEN-1]};
        // Remainder stays below the divisor, so diff[XLEN] is a clean borrow flag.
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            nxt_hi_c = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            nxt_lo_c = {acc_lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            nxt_hi_c = sum[XLEN:1];
            nxt_lo_c = {sum[0], acc_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MIPS multiply/divide unit with HI/LO registers and EX-stage stall request.
module mdu_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic                mthi,
    input  logic                mtlo,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rd_hilo,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     hi,
    output logic [XLEN-1:0]     lo,
    output logic                stall
);

    localparam int unsigned CNT_W  = $clog2(XLEN);
    localparam int unsigned PROD_W = 2 * XLEN;

    mdu_state_e       state;
    mdu_state_e       state_nxt;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opnd;
    mdu_flags_t       flags;
    mdu_flags_t       flags_in;

    logic             is_div_in;
    logic             is_signed_in;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN-1:0]  step_hi;
    logic [XLEN-1:0]  step_lo;
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  res_hi;
    logic [XLEN-1:0]  res_lo;

    // Next-state logic; a new operation is accepted only from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (cnt == '0) begin
                    state_nxt = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_nxt = MDU_DONE;
            end
            MDU_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = MDU_CALC;
                end else begin
                    state_nxt = MDU_IDLE;
                end
            end
            default: begin
                state_nxt = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == MDU_CALC) || (state_nxt == MDU_FIX);
            done  <= (state_nxt == MDU_DONE);
        end
    end

    // Operand magnitudes and result signs captured at start.
    always_comb begin
        is_div_in        = (op == MDU_DIV) || (op == MDU_DIVU);
        is_signed_in     = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag            = (is_signed_in && a[XLEN-1]) ? -a : a;
        b_mag            = (is_signed_in && b[XLEN-1]) ? -b : b;
        flags_in.is_div  = is_div_in;
        flags_in.neg_res = is_signed_in & (a[XLEN-1] ^ b[XLEN-1]);
        flags_in.neg_rem = is_div_in & is_signed_in & a[XLEN-1];
        flags_in.div0    = is_div_in & (b == '0);
    end

    mdu_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div   (flags.is_div),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .opnd     (opnd),
        .nxt_hi_c (step_hi),
        .nxt_lo_c (step_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            flags  <= '0;
        end else if (accept) begin
            cnt    <= CNT_W'(XLEN - 1);
            acc_hi <= '0;
            acc_lo <= is_div_in ? a_mag : b_mag;
            opnd   <= is_div_in ? b_mag : a_mag;
            flags  <= flags_in;
        end else if (state == MDU_CALC) begin
            cnt    <= cnt - CNT_W'(1);
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Sign fix-up; divide by zero leaves the dividend in HI and forces LO to all ones.
    always_comb begin
        prod_fix = flags.neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = flags.div0 ? '1 : (flags.neg_res ? -acc_lo : acc_lo);
        rem_fix  = flags.neg_rem ? -acc_hi : acc_hi;
        res_hi   = flags.is_div ? rem_fix : prod_fix[PROD_W-1:XLEN];
        res_lo   = flags.is_div ? quo_fix : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MDU_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (!busy) begin
            if (mthi) begin
                hi <= wdata;
            end
            if (mtlo) begin
                lo <= wdata;
            end
        end
    end

    assign stall = busy & (start | rd_hilo | mthi | mtlo);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: transaction-level reference model plus directed literal cases.
module tb_mdu_ctrl;

    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hilo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: cycles of busy remaining, architectural HI/LO, pending result.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;

    mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = 64'(sx * sy);
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0)
                    r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else
                    r = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'd0)
                    r = {x, 32'hFFFF_FFFF};
                else
                    r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (mthi) m_hi <= wdata;
            if (mtlo) m_lo <= wdata;
            if (start) begin
                m_pend <= ref_op(op, a, b);
                m_left <= int'(XLEN) + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("stall", 32'(stall), 32'((m_left > 0) && (start || rd_hilo || mthi || mtlo)));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle (or after the bound expires).
    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 100);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            4:       v = -32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int nb;
        int ndone;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wdata   = '0;
        rd_hilo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        tick();

        issue(2'b00, 32'hFFFF_FFFF, 32'd7);
        wait_done(n, nb);
        chk("mult_latency", 32'(n), 32'd34);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF9);
        tick();

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, nb);
        chk("multu_busy_cycles", 32'(nb), 32'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();

        issue(2'b10, -32'd7, 32'd2);
        wait_done(n, nb);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        tick();

        issue(2'b11, 32'd5, 32'd0);
        wait_done(n, nb);
        chk("divu0_latency", 32'(n), 32'd34);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd5);
        tick();

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, nb);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        tick();

        // MFHI held during busy; a second start mid-operation must be ignored.
        rd_hilo = 1'b1;
        issue(2'b01, 32'd6, 32'd7);
        repeat (5) tick();
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd3;
        @(negedge clk);
        chk("stall_busy", 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        wait_done(n, nb);
        chk("stall_done", 32'(stall), 32'd0);
        chk("ignored_start_lo", lo, 32'd42);
        chk("ignored_start_hi", hi, 32'd0);
        tick();
        rd_hilo = 1'b0;

        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        @(negedge clk);
        chk("mthi_idle", hi, 32'hA5A5_A5A5);
        chk("mtlo_idle", lo, 32'hA5A5_A5A5);
        tick();
        issue(2'b01, 32'd2, 32'd3);
        mthi  = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_busy_stall", 32'(stall), 32'd1);
        tick();
        mthi = 1'b0;
        @(negedge clk);
        chk("mthi_busy_hi", hi, 32'hA5A5_A5A5);
        wait_done(n, nb);
        chk("mult_small_lo", lo, 32'd6);
        tick();

        // Reset in the middle of a divide.
        issue(2'b10, 32'd1000, 32'd7);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        tick();
        issue(2'b01, 32'd3, 32'd4);
        wait_done(n, nb);
        chk("post_rst_lo", lo, 32'd12);
        chk("post_rst_hi", hi, 32'd0);
        tick();

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 2500; i++) begin
            start   = ($urandom_range(0, 5) == 0);
            op      = 2'($urandom_range(0, 3));
            a       = pick_operand();
            b       = pick_operand();
            rd_hilo = ($urandom_range(0, 3) == 0);
            mthi    = ($urandom_range(0, 7) == 0);
            mtlo    = ($urandom_range(0, 7) == 0);
            wdata   = $urandom;
            rst_n   = ($urandom_range(0, 399) != 0);
            tick();
        end

        start   = 1'b0;
        rd_hilo = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        rst_n   = 1'b1;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
